// File: rtl/uart_req_initiator.sv
// Sends one 8N1 request byte on txd, then receives one response byte on rxd or reports a timeout.
// Frame out: 10 bit periods; req_ready only in IDLE, so requests wait until the previous exchange ends.
module uart_req_initiator #(
  parameter int CLK_PER_BIT  = 5208,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic       CLK,
  input  logic       RST_X,
  input  logic       req_valid,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       txd,
  input  logic       rxd,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_error,
  output logic       resp_timeout,
  output logic       busy
);

  localparam int BW = $clog2(CLK_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_BITS * CLK_PER_BIT);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLK_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_BITS * CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, TX_START, TX_DATA, TX_STOP, RX_WAIT, RX_START, RX_DATA, RX_STOP
  } state_t;

  state_t        state, state_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n, cnt_step;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          rxd_q1, rxd_s;
  logic          txd_n, resp_valid_n, resp_error_n, resp_timeout_n;
  logic [7:0]    resp_data_n;
  logic          bit_tick;

  assign bit_tick = (bit_cnt == '0);
  assign cnt_step = bit_tick ? BIT_LAST : bit_cnt - 1'b1;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      to_cnt       <= '0;
      rxd_q1       <= 1'b1;
      rxd_s        <= 1'b1;
      txd          <= 1'b1;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_error   <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      bit_idx      <= bit_idx_n;
      shreg        <= shreg_n;
      to_cnt       <= to_cnt_n;
      rxd_q1       <= rxd;
      rxd_s        <= rxd_q1;
      txd          <= txd_n;
      req_ready    <= (state_n == IDLE);
      busy         <= (state_n != IDLE);
      resp_valid   <= resp_valid_n;
      resp_data    <= resp_data_n;
      resp_error   <= resp_error_n;
      resp_timeout <= resp_timeout_n;
    end
  end

  always_comb begin
    state_n        = state;
    bit_cnt_n      = bit_cnt;
    bit_idx_n      = bit_idx;
    shreg_n        = shreg;
    to_cnt_n       = to_cnt;
    txd_n          = txd;
    resp_valid_n   = 1'b0;
    resp_data_n    = resp_data;
    resp_error_n   = resp_error;
    resp_timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          shreg_n   = req_data;
          bit_cnt_n = BIT_LAST;
          txd_n     = 1'b0;
          state_n   = TX_START;
        end
      end
      TX_START: begin
        bit_cnt_n = cnt_step;
        if (bit_tick) begin
          txd_n     = shreg[0];
          shreg_n   = {1'b0, shreg[7:1]};
          bit_idx_n = '0;
          state_n   = TX_DATA;
        end
      end
      TX_DATA: begin
        bit_cnt_n = cnt_step;
        if (bit_tick) begin
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            txd_n   = 1'b1;
            state_n = TX_STOP;
          end else begin
            txd_n   = shreg[0];
            shreg_n = {1'b0, shreg[7:1]};
          end
        end
      end
      TX_STOP: begin
        bit_cnt_n = cnt_step;
        if (bit_tick) begin
          to_cnt_n = '0;
          state_n  = RX_WAIT;
        end
      end
      RX_WAIT: begin
        // Saturating; a start bit seen on the expiry cycle still wins
        if (to_cnt != TO_LAST) to_cnt_n = to_cnt + 1'b1;
        if (!rxd_s) begin
          bit_cnt_n = HALF_LAST;
          state_n   = RX_START;
        end else if (to_cnt == TO_LAST) begin
          resp_timeout_n = 1'b1;
          state_n        = IDLE;
        end
      end
      RX_START: begin
        bit_cnt_n = cnt_step;
        if (bit_tick) begin
          bit_idx_n = '0;
          state_n   = rxd_s ? RX_WAIT : RX_DATA;
        end
      end
      RX_DATA: begin
        bit_cnt_n = cnt_step;
        if (bit_tick) begin
          shreg_n   = {rxd_s, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        // Linger one cycle after the pulse so req_ready rises the cycle after resp_valid
        if (resp_valid) begin
          state_n = IDLE;
        end else begin
          bit_cnt_n = cnt_step;
          if (bit_tick) begin
            resp_data_n  = shreg;
            resp_error_n = ~rxd_s;
            resp_valid_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_req_initiator.sv
// Random request/response exchanges against a queue-based scoreboard and a frame-level UART model.
module tb_uart_req_initiator;
  localparam int CPB = 8;
  localparam int TOB = 4;

  logic       CLK = 1'b0;
  logic       RST_X = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       rxd = 1'b1;
  logic       req_ready, txd, resp_valid, resp_error, resp_timeout, busy;
  logic [7:0] resp_data;

  uart_req_initiator #(.CLK_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .CLK(CLK), .RST_X(RST_X), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .txd(txd), .rxd(rxd), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_error(resp_error), .resp_timeout(resp_timeout),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         is_to;
    logic [7:0] data;
    bit         err;
    int         at;
  } exp_t;
  exp_t sbq[$];
  logic [7:0] last_data = 8'h00;
  bit ready_due = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every pulse must match the oldest expected response
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (ready_due) begin
        chk("ready_after_resp", req_ready, 1);
        ready_due = 1'b0;
      end
      if (resp_valid || resp_timeout) begin
        if (sbq.size() == 0) begin
          chk("unexpected_pulse", {resp_valid, resp_timeout}, 0);
        end else begin
          e = sbq.pop_front();
          chk("resp_timeout_flag", resp_timeout, e.is_to);
          chk("resp_valid_flag", resp_valid, !e.is_to);
          chk("resp_data", resp_data, e.data);
          if (!e.is_to) chk("resp_error", resp_error, e.err);
          if (e.at >= 0) chk("timeout_cycle", cyc, e.at);
          if (resp_valid) begin
            chk("ready_low_at_resp", req_ready, 0);
            ready_due = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_ready;
    int n = 0;
    while (!req_ready && n < 400) begin
      tick;
      n++;
    end
    chk("wait_ready", req_ready, 1);
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 400) begin
      tick;
      n++;
    end
    chk("wait_idle", busy, 0);
    tick;
  endtask

  // Issues a request and checks the whole serial frame; returns the cycle the stop bit ends
  task automatic send(input logic [7:0] b, input bit intrude, output int stop_end);
    logic [9:0] fr;
    int bad;
    int rb_bad;
    rb_bad = 0;
    wait_ready;
    req_valid = 1'b1;
    req_data = b;
    tick;
    if (intrude) req_data = 8'hFF;
    else req_valid = 1'b0;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int j = 0; j < CPB; j++) begin
        if (txd !== fr[k]) bad++;
        if (req_ready !== 1'b0 || busy !== 1'b1) rb_bad++;
        tick;
      end
      chk($sformatf("txd_%02h_bit%0d_errs", b, k), bad, 0);
    end
    req_valid = 1'b0;
    chk("ready_busy_during_tx", rb_bad, 0);
    stop_end = cyc;
  endtask

  task automatic uart_reply(input logic [7:0] b, input bit stop);
    rxd = 1'b0;
    repeat (CPB) tick;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) tick;
    end
    rxd = stop;
    repeat (CPB) tick;
    rxd = 1'b1;
  endtask

  task automatic glitch;
    rxd = 1'b0;
    tick;
    tick;
    rxd = 1'b1;
  endtask

  task automatic expect_reply(input logic [7:0] b, input bit stop);
    exp_t e;
    e.is_to = 1'b0; e.data = b; e.err = !stop; e.at = -1;
    sbq.push_back(e);
    last_data = b;
  endtask

  task automatic expect_timeout(input int at);
    exp_t e;
    e.is_to = 1'b1; e.data = last_data; e.err = 1'b0; e.at = at;
    sbq.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_txd"}, txd, 1);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_data"}, resp_data, 0);
    chk({tag, "_resp_error"}, resp_error, 0);
    chk({tag, "_resp_timeout"}, resp_timeout, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int se;
    logic [7:0] b;
    int mode;
    int d;
    bit stop;

    repeat (3) tick;
    #2 RST_X = 1'b0;
    #1 check_reset_outputs("reset_async");
    tick;
    RST_X = 1'b1;
    tick;
    chk("release_req_ready", req_ready, 1);
    chk("release_txd", txd, 1);

    // 0xA5 with an intruding request held during the frame, reply 0x3C after 16 cycles
    send(8'hA5, 1'b1, se);
    repeat (16) tick;
    expect_reply(8'h3C, 1'b1);
    uart_reply(8'h3C, 1'b1);
    wait_idle;

    // No reply
    send(8'h5A, 1'b0, se);
    expect_timeout(se + TOB * CPB);
    wait_idle;

    // Glitch rejected, then framing error
    send(8'h11, 1'b0, se);
    repeat (3) tick;
    glitch;
    repeat (8) tick;
    chk("busy_after_glitch", busy, 1);
    expect_reply(8'h81, 1'b0);
    uart_reply(8'h81, 1'b0);
    wait_idle;

    // Reset in the middle of the data bits
    wait_ready;
    req_valid = 1'b1;
    req_data = 8'hC3;
    tick;
    req_valid = 1'b0;
    repeat (30) tick;
    #2 RST_X = 1'b0;
    #1 check_reset_outputs("reset_mid_tx");
    last_data = 8'h00;
    tick;
    RST_X = 1'b1;
    tick;
    send(8'h00, 1'b0, se);
    repeat (5) tick;
    expect_reply(8'h7E, 1'b1);
    uart_reply(8'h7E, 1'b1);
    wait_idle;

    for (int t = 0; t < 24; t++) begin
      b = 8'($urandom);
      mode = $urandom_range(0, 3);
      send(b, mode[0], se);
      case (mode)
        0: begin
          expect_timeout(se + TOB * CPB);
        end
        2: begin
          d = $urandom_range(0, 6);
          repeat (d) tick;
          glitch;
          repeat (6) tick;
          b = 8'($urandom);
          expect_reply(b, 1'b1);
          uart_reply(b, 1'b1);
        end
        default: begin
          d = $urandom_range(0, 20);
          repeat (d) tick;
          b = 8'($urandom);
          stop = (mode == 1) ? 1'b1 : 1'($urandom);
          expect_reply(b, stop);
          uart_reply(b, stop);
        end
      endcase
      wait_idle;
    end

    repeat (20) tick;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_req_initiator.md
Name: uart_req_initiator

Overview:
- Host-side initiator for the byte-echo UART service that the design's responder thread implements.
- Serializes one request byte onto txd (8N1), then waits for and deserializes exactly one response byte from rxd.
- Reports the response, or a timeout if none arrives within a bounded window.
- Bit timing uses a cycle-count divider and a half-bit start qualification, matching the existing UART blocks so the two ends interoperate at the same baud.

Parameters:
- CLK_PER_BIT, 5208, clock cycles per UART bit (100 MHz / 19200 baud); must be >= 4.
- TIMEOUT_BITS, 40, bit periods to wait for a response start bit after the request stop bit ends.

Ports:
- CLK  in  1  sole clock
- RST_X  in  1  reset, asynchronous, active-low
- req_valid  in  1  request byte offered
- req_data  in  8  request byte
- req_ready  out  1  high only in IDLE; transfer occurs when req_valid && req_ready at a CLK edge
- txd  out  1  UART serial out, idle high
- rxd  in  1  UART serial in, asynchronous
- resp_valid  out  1  one-cycle pulse: response byte complete
- resp_data  out  8  received byte; held until the next resp_valid
- resp_error  out  1  qualified by resp_valid; 1 = stop bit sampled low (framing error)
- resp_timeout  out  1  one-cycle pulse: no response start bit within the timeout window
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (RST_X low, takes effect immediately without waiting for CLK):
  - state IDLE; txd=1, req_ready=1, resp_valid=0, resp_data=0, resp_error=0, resp_timeout=0, busy=0.
  - rxd synchronizer flops and all counters cleared; sync flops reset to 1.
  - Reset mid-frame abandons the transaction. No partial pulse is emitted.
- rxd input: 2-flop synchronizer. All receive decisions use the synchronized value (2-cycle latency).
- All outputs are registered.
- FSM states: IDLE, TX_START, TX_DATA, TX_STOP, RX_WAIT, RX_START, RX_DATA, RX_STOP.
- IDLE:
  - On transfer, latch req_data into the shift register and load the bit counter with CLK_PER_BIT-1.
  - On the same edge: txd<=0, req_ready<=0, busy<=1, go TX_START.
  - req_valid while not in IDLE is ignored; the request is not latched.
- TX_START / TX_DATA / TX_STOP:
  - Each bit is held exactly CLK_PER_BIT cycles: the counter decrements to 0, then reloads.
  - TX_DATA shifts out 8 bits LSB first, counted by a 3-bit index.
  - TX_STOP drives txd=1. At the end of TX_STOP, clear the timeout counter and go RX_WAIT.
  - Whole frame: 10*CLK_PER_BIT cycles from the txd falling edge.
- RX_WAIT:
  - The timeout counter increments every cycle.
  - Synced rxd==0: load the counter with CLK_PER_BIT/2-1 (integer division), go RX_START.
  - Counter reaching TIMEOUT_BITS*CLK_PER_BIT-1 with no start: resp_timeout<=1 for one cycle, go IDLE. resp_data is unchanged.
  - Simultaneous start detect and timeout expiry in the same cycle: start wins.
- RX_START:
  - When the counter reaches 0, sample synced rxd.
  - rxd==0: reload CLK_PER_BIT-1, go RX_DATA.
  - rxd==1 (glitch): return to RX_WAIT. The timeout counter is not cleared; it keeps counting from its accumulated value.
- RX_DATA: sample once per CLK_PER_BIT at mid-bit, shift in LSB first, 8 samples, then go RX_STOP.
- RX_STOP:
  - At mid-stop-bit, set resp_data<=shift register, resp_error<=~rxd, resp_valid<=1 (one cycle).
  - Then go IDLE with req_ready<=1, busy<=0.
  - The next request may be accepted in the cycle after resp_valid.
- rxd activity in IDLE or TX_* states is ignored.
- Counters:
  - bit counter width clog2(CLK_PER_BIT).
  - timeout counter width clog2(TIMEOUT_BITS*CLK_PER_BIT); it saturates (no wrap).

Test Plan:
(CLK_PER_BIT=8, TIMEOUT_BITS=4 unless noted)
- Reset:
  - Assert RST_X low asynchronously mid-cycle -> all outputs at reset values before the next CLK edge.
  - Release -> req_ready=1, txd=1.
- Send 0xA5:
  - txd holds 0,1,0,1,0,0,1,0,1,1, each exactly 8 cycles (80 total).
  - req_ready=0 and busy=1 throughout.
  - A second req_valid=1 with 0xFF during the frame is not accepted.
- Bench model replies 0x3C, start bit 16 cycles after the stop bit ends:
  - resp_valid pulses exactly once, resp_data=0x3C, resp_error=0.
  - req_ready returns to 1 the following cycle.
- No reply -> resp_timeout pulses once 32 cycles after the stop bit ends; resp_valid stays 0; resp_data keeps the previous value 0x3C.
- Glitch and framing error:
  - rxd low for 2 cycles during RX_WAIT -> rejected, no pulse.
  - Then a valid 0x81 frame with stop bit driven 0 -> resp_valid=1, resp_data=0x81, resp_error=1.
- Reset mid-TX_DATA:
  - RST_X low -> txd=1 immediately, no resp_* pulse.
  - After release, a new request 0x00 transmits a correct frame.
